// File: rtl/isa_pkg.sv
// Shared ISA constants, instruction field positions and fetch-stage types
// for the 16-bit, 16-register pipelined core.
package isa_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [3:0]         OPC_HLT   = 4'b1111;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  // Opcode 0 guarantees a bubble is never mistaken for HLT.
  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: the fetch stage drives the address, memory
// answers with data and a valid flag in the same cycle.
interface fetch_stage_if;
  import isa_pkg::*;

  logic [PC_W-1:0]    addr;
  logic [INSTR_W-1:0] rdata;
  logic               valid;

  modport master (output addr, input rdata, input valid);
  modport slave  (input addr, output rdata, output valid);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load; with neither asserted it holds.
module if_id_reg
  import isa_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   load,
  input  if_id_t load_data,
  output if_id_t q
);

  if_id_t stage_d, stage_q;

  always_comb begin
    // NOTE: assigning the hold value first means no path leaves stage_d unassigned, so no latch.
    stage_d = stage_q;
    if (flush) begin
      stage_d = IF_ID_BUBBLE;
    end else if (load) begin
      stage_d = load_data;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= IF_ID_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALT control and redirect/stall priority
// in front of the IF/ID pipeline register.
module fetch_stage
  import isa_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write,
  input  logic               if_id_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic [3:0]         if_id_opcode,
  output logic [3:0]         if_id_rs,
  output logic [3:0]         if_id_rt,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(2);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(1);

  logic [PC_W-1:0] pc_q, pc_d, pc_plus2;
  fetch_state_e    state_q, state_d;
  logic            flush, load;
  if_id_t          load_data, if_id_q;

  assign pc_plus2  = pc_q + PC_STEP;
  assign load_data = '{instr: imem.rdata, pc: pc_plus2, valid: 1'b1};

  // Priority: redirect, halt freeze, hazard stall, memory not ready, fetch.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    flush   = 1'b0;
    load    = 1'b0;
    if (branch_taken) begin
      pc_d    = branch_target & ALIGN_MASK;
      flush   = 1'b1;
      state_d = RUN;
    end else if (state_q == HALT) begin
      // frozen until a redirect or reset
    end else if (!if_id_write) begin
      // stall: IF/ID and PC hold together so nothing is replayed or lost
    end else if (!imem.valid) begin
      flush = 1'b1;
    end else begin
      load = 1'b1;
      if (opcode_of(imem.rdata) == OPC_HLT) begin
        state_d = HALT;
      end else if (pc_write) begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC & ALIGN_MASK;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load),
    .load_data (load_data),
    .q         (if_id_q)
  );

  assign imem.addr    = pc_q;
  assign if_id_instr  = if_id_q.instr;
  assign if_id_pc     = if_id_q.pc;
  assign if_id_valid  = if_id_q.valid;
  assign if_id_opcode = if_id_q.instr[OPC_HI:OPC_LO];
  assign if_id_rs     = if_id_q.instr[RS_HI:RS_LO];
  assign if_id_rt     = if_id_q.instr[RT_HI:RT_LO];
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stimulus
// compared every cycle against a rule-level model of the fetch stage.
module tb_fetch_stage;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_write, if_id_write, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] if_id_instr, if_id_pc;
  logic        if_id_valid, halted;
  logic [3:0]  if_id_opcode, if_id_rs, if_id_rt;
  logic        check_en = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .if_id_opcode  (if_id_opcode),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Architectural view of the stage: PC, latched slot and halt flag.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic        valid;
    logic        halted;
  } model_t;

  localparam model_t MODEL_RESET = '{pc: 16'h0000, instr: 16'h0000, ipc: 16'h0000,
                                     valid: 1'b0, halted: 1'b0};

  model_t m = MODEL_RESET;

  function automatic logic [15:0] add2(input logic [15:0] a);
    return 16'((32'(a) + 2) % 65536);
  endfunction

  function automatic model_t model_next(input model_t s, input logic pcw, input logic idw,
                                        input logic bt, input logic [15:0] tgt,
                                        input logic v, input logic [15:0] rd);
    model_t n = s;
    if (bt) begin
      n        = MODEL_RESET;
      n.pc     = {tgt[15:1], 1'b0};
    end else if (s.halted || !idw) begin
      n = s;
    end else if (!v) begin
      n.instr = 16'h0000;
      n.ipc   = 16'h0000;
      n.valid = 1'b0;
    end else begin
      n.instr = rd;
      n.ipc   = add2(s.pc);
      n.valid = 1'b1;
      if (rd[15:12] == 4'hF) n.halted = 1'b1;
      else if (pcw)          n.pc     = add2(s.pc);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= MODEL_RESET;
    else m <= model_next(m, pc_write, if_id_write, branch_taken, branch_target,
                         imem_bus.valid, imem_bus.rdata);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      check("m_imem_addr", imem_bus.addr, m.pc);
      check("m_instr", if_id_instr, m.instr);
      check("m_pc", if_id_pc, m.ipc);
      check("m_valid", 16'(if_id_valid), 16'(m.valid));
      check("m_opcode", 16'(if_id_opcode), 16'(m.instr[15:12]));
      check("m_rs", 16'(if_id_rs), 16'(m.instr[7:4]));
      check("m_rt", 16'(if_id_rt), 16'(m.instr[3:0]));
      check("m_halted", 16'(halted), 16'(m.halted));
    end
  end

  task automatic step(input logic pcw, input logic idw, input logic bt,
                      input logic [15:0] tgt, input logic v, input logic [15:0] rd);
    pc_write       = pcw;
    if_id_write    = idw;
    branch_taken   = bt;
    branch_target  = tgt;
    imem_bus.valid = v;
    imem_bus.rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, imem_bus.addr, 16'h0000);
    check({tag, "_instr"}, if_id_instr, 16'h0000);
    check({tag, "_pc"}, if_id_pc, 16'h0000);
    check({tag, "_valid"}, 16'(if_id_valid), 16'h0000);
    check({tag, "_halted"}, 16'(halted), 16'h0000);
  endtask

  initial begin
    pc_write = 1'b1; if_id_write = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000;
    imem_bus.valid = 1'b1; imem_bus.rdata = 16'h0000;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Straight-line fetch
    step(1, 1, 0, 16'h0, 1, 16'h1234);
    check("fetch1_instr", if_id_instr, 16'h1234);
    check("fetch1_pc", if_id_pc, 16'h0002);
    check("fetch1_valid", 16'(if_id_valid), 16'h0001);
    step(1, 1, 0, 16'h0, 1, 16'h2345);
    check("fetch2_pc", if_id_pc, 16'h0004);
    check("fetch2_addr", imem_bus.addr, 16'h0004);

    // Three-cycle stall, then resume without skipping
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 16'h0, 1, 16'h3456);
      check("stall_instr", if_id_instr, 16'h2345);
      check("stall_addr", imem_bus.addr, 16'h0004);
    end
    step(1, 1, 0, 16'h0, 1, 16'h3456);
    check("resume_pc", if_id_pc, 16'h0006);
    check("resume_addr", imem_bus.addr, 16'h0006);

    // Redirect during a stall
    step(0, 0, 1, 16'h0100, 1, 16'hAAAA);
    check("redir_valid", 16'(if_id_valid), 16'h0000);
    check("redir_instr", if_id_instr, 16'h0000);
    check("redir_addr", imem_bus.addr, 16'h0100);
    step(1, 1, 0, 16'h0, 1, 16'h4567);
    check("redir_pc", if_id_pc, 16'h0102);

    // HLT at 0x0010 (odd target bit dropped), then release by redirect
    step(1, 1, 1, 16'h0011, 1, 16'h0000);
    check("align_addr", imem_bus.addr, 16'h0010);
    step(1, 1, 0, 16'h0, 1, 16'hF000);
    check("hlt_halted", 16'(halted), 16'h0001);
    check("hlt_opcode", 16'(if_id_opcode), 16'h000F);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 16'h0, 1, 16'($urandom));
      check("halt_addr", imem_bus.addr, 16'h0010);
      check("halt_instr", if_id_instr, 16'hF000);
    end
    step(1, 1, 1, 16'h0020, 1, 16'h0000);
    check("unhalt_halted", 16'(halted), 16'h0000);
    check("unhalt_addr", imem_bus.addr, 16'h0020);
    step(1, 1, 0, 16'h0, 1, 16'h1111);
    check("unhalt_pc", if_id_pc, 16'h0022);

    // Memory not ready for two cycles
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 16'h0, 0, 16'h5555);
      check("nrdy_valid", 16'(if_id_valid), 16'h0000);
      check("nrdy_addr", imem_bus.addr, 16'h0022);
    end
    step(1, 1, 0, 16'h0, 1, 16'h2222);
    check("rdy_pc", if_id_pc, 16'h0024);
    check("rdy_addr", imem_bus.addr, 16'h0024);

    // Stall wins over memory-not-ready; pc_write=0 alone still loads IF/ID
    step(0, 0, 0, 16'h0, 0, 16'h7777);
    check("stall_nrdy_instr", if_id_instr, 16'h2222);
    check("stall_nrdy_valid", 16'(if_id_valid), 16'h0001);
    step(0, 1, 0, 16'h0, 1, 16'h6666);
    check("pcw0_instr", if_id_instr, 16'h6666);
    check("pcw0_addr", imem_bus.addr, 16'h0024);

    // PC wrap
    step(1, 1, 1, 16'hFFFE, 1, 16'h0000);
    step(1, 1, 0, 16'h0, 1, 16'h3333);
    check("wrap_addr", imem_bus.addr, 16'h0000);
    check("wrap_pc", if_id_pc, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, ($urandom % 6) != 0, ($urandom % 12) == 0,
           (($urandom % 4) == 0) ? 16'hFFFC : 16'($urandom),
           ($urandom % 5) != 0, 16'($urandom));
    end

    // Async reset while halted
    step(1, 1, 1, 16'h0040, 1, 16'h0000);
    step(1, 1, 0, 16'h0, 1, 16'hF123);
    check("pre_rst_halted", 16'(halted), 16'h0001);
    step(0, 0, 0, 16'h0, 1, 16'h0000);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 16'h0, 1, 16'h1234);
    check("post_rst_pc", if_id_pc, 16'h0002);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
